// File: rtl/param_shift_register_if.sv
// Bundles the control, data and status signals of param_shift_register.
// The master drives requests and load data; the slave returns register state and status.
interface param_shift_register_if #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH) + 1
);
    logic             ld;
    logic [WIDTH-1:0] d_in;
    logic             start;
    logic [2:0]       op;
    logic [CW-1:0]    amt;
    logic             sin;
    logic [WIDTH-1:0] out;
    logic             ser_out;
    logic             busy;
    logic             done;

    modport master (
        output ld, d_in, start, op, amt, sin,
        input  out, ser_out, busy, done
    );

    modport slave (
        input  ld, d_in, start, op, amt, sin,
        output out, ser_out, busy, done
    );
endinterface

// File: rtl/param_shift_register.sv
// Multi-cycle shift/rotate register: a start request latches an op and a step count,
// and the register then performs one single-bit step per clock until the count runs out.
module param_shift_register #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    param_shift_register_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    state_t           state_q;
    logic [WIDTH-1:0] out_q;
    logic             ser_q;
    logic [2:0]       op_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   step_d;

    // One single-bit step; result is {bit expelled or wrapped, new register value}.
    // The reserved op reproduces the current value and serial bit unchanged.
    function automatic logic [WIDTH:0] step_f(
        input logic [2:0]       op_v,
        input logic [WIDTH-1:0] v,
        input logic             s,
        input logic             ser_v
    );
        logic [WIDTH:0] r;
        case (op_v)
            3'b000:  r = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
            3'b001:  r = {v[0], 1'b0, v[WIDTH-1:1]};
            3'b010:  r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
            3'b011:  r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
            3'b100:  r = {v[0], v[0], v[WIDTH-1:1]};
            3'b101:  r = {v[WIDTH-1], v[WIDTH-2:0], s};
            3'b110:  r = {v[0], s, v[WIDTH-1:1]};
            default: r = {ser_v, v};
        endcase
        return r;
    endfunction

    // Next register value and serial bit for a step of the latched op.
    always_comb begin
        step_d = step_f(op_q, out_q, bus.sin, ser_q);
    end

    // Control FSM together with the data, serial-bit and step-counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            out_q   <= {WIDTH{1'b0}};
            ser_q   <= 1'b0;
            op_q    <= 3'b000;
            cnt_q   <= CNT_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A load in the same cycle as a start wins and the start is dropped.
                    if (bus.ld) begin
                        out_q <= bus.d_in;
                    end else if (bus.start) begin
                        op_q    <= bus.op;
                        cnt_q   <= bus.amt;
                        state_q <= (bus.amt == CNT_ZERO) ? ST_DONE : ST_SHIFT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    {ser_q, out_q} <= step_d;
                    cnt_q          <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.out     = out_q;
    assign bus.ser_out = ser_q;
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.done    = (state_q == ST_DONE);

endmodule

// File: doc/param_shift_register.md
PARAM_SHIFT_REGISTER -- requirements
Module: param_shift_register

Interface
REQ-001 Parameter WIDTH, default 8, data register width in bits; SHALL be >= 2.
REQ-002 Parameter CW, default $clog2(WIDTH)+1, shift-amount width in bits.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 ld  input  1  parallel load request.
REQ-006 d_in  input  WIDTH  parallel load data.
REQ-007 start  input  1  begin a multi-cycle shift operation.
REQ-008 op  input  3  operation select, sampled with start.
REQ-009 amt  input  CW  number of single-bit steps, sampled with start.
REQ-010 sin  input  1  serial fill bit, used by ops 101/110; sampled on every step edge.
REQ-011 out  output  WIDTH  register contents.
REQ-012 ser_out  output  1  bit expelled or wrapped by the most recent step.
REQ-013 busy  output  1  high while state is SHIFT or DONE.
REQ-014 done  output  1  one-cycle completion pulse.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT and DONE; all outputs are registered or decoded from state only.
REQ-016 In IDLE with ld=1, out SHALL take d_in at the edge; state remains IDLE.
REQ-017 In IDLE with ld=0 and start=1, op and amt SHALL be latched; if amt>0, next state is SHIFT with step counter = amt; if amt=0, next state is DONE with out unchanged.
REQ-018 ld=1 and start=1 in the same IDLE cycle: load SHALL win and start is dropped.
REQ-019 ld and start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-020 In SHIFT, each edge performs exactly one single-bit step of the latched op and decrements the counter; the step at counter=1 also moves state to DONE.
REQ-021 op 000 SLL: shift toward MSB, fill LSB with 0; ser_out = old MSB.
REQ-022 op 001 SRL: shift toward LSB, fill MSB with 0; ser_out = old LSB.
REQ-023 op 010 SRA: shift toward LSB, MSB replicated; ser_out = old LSB.
REQ-024 op 011 ROL: old MSB enters LSB; ser_out = old MSB.
REQ-025 op 100 ROR: old LSB enters MSB; ser_out = old LSB.
REQ-026 op 101 serial-left: as SLL but LSB filled with sin; op 110 serial-right: as SRL but MSB filled with sin.
REQ-027 op 111 reserved: each step SHALL leave out and ser_out unchanged; the counter and done timing are as for any other op.
REQ-028 amt > WIDTH SHALL be honoured literally (e.g. ROR by WIDTH+1 equals ROR by 1; SLL by >= WIDTH yields 0).
REQ-029 DONE lasts exactly one cycle with done=1, then returns to IDLE; latency from the start edge to done high is amt+1 cycles (1 cycle for amt=0).
REQ-030 ser_out SHALL hold its value when no step occurs.

Reset
REQ-031 While reset=0, out, ser_out, busy and done SHALL all be 0 and the state SHALL be IDLE, regardless of clk.
REQ-032 Reset asserted mid-operation SHALL abort the operation; no done pulse follows deassertion.
REQ-033 After reset deasserts, the first edge with ld or start SHALL be honoured normally.

Verification (WIDTH=8)
REQ-034 Load 0x96; start op=000 amt=3 -> out=0xB0, ser_out=0, done high exactly 4 cycles after the start edge, busy high for 4 cycles.
REQ-035 Load 0x96; start op=010 amt=2 -> out=0xE5; then op=100 amt=9 from a fresh load of 0x96 -> out=0x4B, ser_out=0.
REQ-036 Load 0x00; op=101 amt=4, sin held 1 -> out=0x0F; op=110 amt=8, sin=0 -> out=0x00.
REQ-037 start with amt=0 -> out unchanged, done pulses 1 cycle after start; ld and start pulsed during busy -> out unaffected by them, no second done.
REQ-038 Assert reset during step 2 of op=011 amt=5 -> out=0, busy=0, done=0 immediately; no done after release.
REQ-039 ld=1 and start=1 in the same cycle with d_in=0x3C -> out=0x3C, busy stays 0.
